// File: rtl/gate_test_sequencer.sv
// Walks a 2-input gate through vectors 00..11, waits a settle time,
// and checks each sampled output against an expected truth table.
module gate_test_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  TRUTH_TABLE   = 4'b0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_y,
    output logic       drv_in1,
    output logic       drv_in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_mask
);

    localparam logic [3:0] SETTLE_W = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_vec;
    logic [3:0] r_wcnt;
    logic       r_pass;
    logic [2:0] r_err_count;
    logic [3:0] r_err_mask;
    logic       w_miss;
    logic       w_accept;

    assign w_miss   = (gate_y != TRUTH_TABLE[r_vec]);
    // DONE also accepts start so a held start runs back-to-back
    assign w_accept = start && !abort &&
                      (r_state == S_IDLE || r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:   if (start) w_next = S_DRIVE;
                S_DRIVE:  w_next = (SETTLE_W == 4'd0) ? S_SAMPLE : S_SETTLE;
                S_SETTLE: if (r_wcnt <= 4'd1) w_next = S_SAMPLE;
                S_SAMPLE: w_next = (r_vec == 2'd3) ? S_DONE : S_DRIVE;
                S_DONE:   w_next = start ? S_DRIVE : S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vec       <= 2'd0;
            r_wcnt      <= 4'd0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_err_mask  <= 4'd0;
        end else begin
            r_state <= w_next;
            if (abort && r_state != S_IDLE) begin
                r_vec  <= 2'd0;
                r_wcnt <= 4'd0;
                r_pass <= 1'b0;
            end else if (w_accept) begin
                r_vec       <= 2'd0;
                r_pass      <= 1'b0;
                r_err_count <= 3'd0;
                r_err_mask  <= 4'd0;
            end else begin
                case (r_state)
                    S_DRIVE:  r_wcnt <= SETTLE_W;
                    S_SETTLE: r_wcnt <= r_wcnt - 4'd1;
                    S_SAMPLE: begin
                        if (w_miss) begin
                            if (r_err_count != 3'd4)
                                r_err_count <= r_err_count + 3'd1;
                            r_err_mask[r_vec] <= 1'b1;
                        end
                        if (r_vec != 2'd3)
                            r_vec <= r_vec + 2'd1;
                        else
                            r_pass <= (r_err_count == 3'd0) && !w_miss;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign drv_in1   = r_vec[1];
    assign drv_in2   = r_vec[0];
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign err_mask  = r_err_mask;

endmodule
